// File: rtl/im_loader_if.sv
// im_loader_if: bundles the half-word source stream and the instruction-memory
// write port of the boot loader.
//   s_valid/s_data/s_ready : 16-bit valid/ready stream into the loader
//   im_we/im_addr/im_wdata : one-cycle write strobe into instruction memory
// Modports:
//   master : the environment side (drives the stream, observes memory writes)
//   slave  : the loader side (accepts the stream, drives memory writes)
interface im_loader_if #(
    parameter int ADDR_W = 16
);
    logic              s_valid;
    logic [15:0]       s_data;
    logic              s_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (output s_valid, s_data, input s_ready, im_we, im_addr, im_wdata);
    modport slave  (input s_valid, s_data, output s_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/im_loader.sv
// im_loader: boot-time writer for the SISC instruction memory.
// Takes a stream of 16-bit half-words (high half first), packs each pair into
// a 32-bit instruction and writes it to sequential addresses from 0. The CPU
// is held in reset (cpu_rst_f=0) until a load completes.
// Ports:
//   clk, rst_f       : clock (rising edge), asynchronous active-low reset
//   load_start       : one-cycle load request, sampled in IDLE only
//   load_count       : number of 32-bit instructions, sampled with load_start
//   bus (slave)      : half-word stream in, instruction-memory write out
//   cpu_rst_f        : active-low processor reset hold
//   busy             : load in progress
//   done             : one-cycle pulse when a load completes
//   chk_ok           : trailer matched the XOR of written words (option only)
// Option IM_LOADER_CHECKSUM_EN: after the last write a 32-bit trailer is
// received and compared to a running XOR; the CPU is released only on match.
// All outputs are registered; they are loaded from the next state so that
// each state's outputs are visible exactly while the FSM is in that state.
module im_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_count,
    im_loader_if.slave        bus,
    output logic              cpu_rst_f,
    output logic              busy,
`ifdef IM_LOADER_CHECKSUM_EN
    output logic              chk_ok,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
`ifdef IM_LOADER_CHECKSUM_EN
        CK_HI = 3'd5,
        CK_LO = 3'd6,
`endif
        DONE  = 3'd4
    } state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] ptr, cnt;
    logic [15:0]       hi;
    logic              hs;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0]       xsum;
    logic [15:0]       tr_hi;
    localparam state_t TAIL = CK_HI;   // state entered once the image is written
`else
    localparam state_t TAIL = DONE;
`endif

    assign hs = bus.s_valid & bus.s_ready;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (load_start) nxt = (load_count == '0) ? TAIL : HI;
            HI:      if (hs) nxt = LO;
            LO:      if (hs) nxt = WRITE;
            // ptr+1 cannot overflow: cnt <= 2^ADDR_W-1 bounds ptr to 2^ADDR_W-2
            WRITE:   nxt = (ptr + ADDR_W'(1) == cnt) ? TAIL : HI;
`ifdef IM_LOADER_CHECKSUM_EN
            CK_HI:   if (hs) nxt = CK_LO;
            CK_LO:   if (hs) nxt = DONE;
`endif
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state        <= IDLE;
            bus.s_ready  <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cpu_rst_f    <= 1'b0;
            ptr          <= '0;
            cnt          <= '0;
            hi           <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            xsum         <= '0;
            tr_hi        <= '0;
            chk_ok       <= 1'b0;
`endif
        end else begin
            state <= nxt;
`ifdef IM_LOADER_CHECKSUM_EN
            bus.s_ready <= (nxt == HI) || (nxt == LO) || (nxt == CK_HI) || (nxt == CK_LO);
`else
            bus.s_ready <= (nxt == HI) || (nxt == LO);
`endif
            bus.im_we <= (nxt == WRITE);
            busy      <= (nxt != IDLE) && (nxt != DONE);
            done      <= (nxt == DONE);
            case (state)
                IDLE: if (load_start) begin
                    cnt       <= load_count;
                    ptr       <= '0;
                    cpu_rst_f <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
                    xsum      <= '0;
`endif
                end
                HI: if (hs) hi <= bus.s_data;
                // The write address/data are staged here so they are stable
                // for the whole cycle im_we is high.
                LO: if (hs) begin
                    bus.im_addr  <= ptr;
                    bus.im_wdata <= {hi, bus.s_data};
                end
                WRITE: begin
                    ptr <= ptr + ADDR_W'(1);
`ifdef IM_LOADER_CHECKSUM_EN
                    xsum <= xsum ^ bus.im_wdata;
`endif
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CK_HI: if (hs) tr_hi <= bus.s_data;
                CK_LO: if (hs) chk_ok <= ({tr_hi, bus.s_data} == xsum);
                DONE:  cpu_rst_f <= chk_ok;
`else
                DONE:  cpu_rst_f <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed self-checking bench for im_loader.
// A queue-driven source feeds half-words (optionally toggling s_valid every
// cycle) and every memory write is captured into a queue for checking.
module tb_im_loader;
    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] load_count = '0;
    logic        cpu_rst_f, busy, done;
`ifdef IM_LOADER_CHECKSUM_EN
    logic        chk_ok;
`endif
    int checks = 0;
    int errors = 0;

    im_loader_if #(.ADDR_W(16)) bus();

    im_loader #(.ADDR_W(16)) dut (
        .clk(clk), .rst_f(rst_f), .load_start(load_start), .load_count(load_count),
        .bus(bus), .cpu_rst_f(cpu_rst_f), .busy(busy),
`ifdef IM_LOADER_CHECKSUM_EN
        .chk_ok(chk_ok),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] src_q[$];
    logic [47:0] wr_q[$];   // {addr, data}
    bit          stall = 1'b0;
    bit          gate  = 1'b0;
    int          acc   = 0;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    end

    // Source and memory model: sample on the edge, update outputs 1ns later.
    always @(posedge clk) begin
        if (bus.im_we) wr_q.push_back({bus.im_addr, bus.im_wdata});
        if (bus.s_valid && bus.s_ready) begin
            void'(src_q.pop_front());
            acc++;
        end
        #1;
        gate = ~gate;
        bus.s_valid = (src_q.size() > 0) && (!stall || gate);
        bus.s_data  = (src_q.size() > 0) ? src_q[0] : 16'h0;
    end

    task automatic push_trailer(input logic [31:0] x);
`ifdef IM_LOADER_CHECKSUM_EN
        src_q.push_back(x[31:16]);
        src_q.push_back(x[15:0]);
`else
        if (x == 32'hFFFF_FFFF) src_q.push_back(16'h0);  // never used; keeps x read
`endif
    endtask

    task automatic start(input logic [15:0] n);
        @(posedge clk); #2;
        load_start = 1'b1;
        load_count = n;
        @(posedge clk); #2;
        load_start = 1'b0;
    endtask

    // Wait for done at negedges; n = negedges elapsed when seen.
    task automatic wait_done(input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            n++;
            if (done) return;
        end
        n = -1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({bus.s_ready, bus.im_we, busy, done, cpu_rst_f} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 00000", {bus.s_ready, bus.im_we, busy, done, cpu_rst_f});
        end
        checks++;
        if (bus.im_addr !== 16'h0 || bus.im_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus: got %h/%h want 0/0", bus.im_addr, bus.im_wdata);
        end
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        bit found;
        wr_q.delete();
        src_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        push_trailer(32'h1234_5678 ^ 32'h9ABC_DEF0);
        @(posedge clk);
        start(2);
        n = 0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            n++;
            if (bus.im_we) found = 1'b1;
        end
        checks++;
        if (!found || n != 3) begin
            errors++; $display("FAIL basic_latency: got %0d cycles want 3", n);
        end
        checks++;
        if (bus.im_addr !== 16'h0 || bus.im_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL basic_first_wr: got %h:%h want 0000:12345678", bus.im_addr, bus.im_wdata);
        end
        wait_done(40, n);
        checks++;
        if (n < 0 || busy !== 1'b0 || cpu_rst_f !== 1'b0) begin
            errors++; $display("FAIL basic_done: n=%0d busy=%b cpu_rst_f=%b want done busy=0 cpu_rst_f=0", n, busy, cpu_rst_f);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cpu_rst_f !== 1'b1) begin
            errors++; $display("FAIL basic_release: done=%b cpu_rst_f=%b want 0 1", done, cpu_rst_f);
        end
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {16'h0, 32'h1234_5678} || wr_q[1] !== {16'h1, 32'h9ABC_DEF0}) begin
            errors++; $display("FAIL basic_writes: got %0d writes, first %h want 2 writes 0:12345678 1:9ABCDEF0", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 48'h0);
        end
    endtask

    task automatic test_stall;
        int n;
        int exp_acc;
        wr_q.delete();
        acc = 0;
        stall = 1'b1;
        src_q = '{16'hAAAA, 16'hBBBB};
        push_trailer(32'hAAAA_BBBB);
        src_q.push_back(16'hCCCC);
`ifdef IM_LOADER_CHECKSUM_EN
        exp_acc = 4;
`else
        exp_acc = 2;
`endif
        @(posedge clk);
        start(1);
        // load_start while busy must be ignored
        @(posedge clk); #2;
        load_start = 1'b1; load_count = 16'd5;
        @(posedge clk); #2;
        load_start = 1'b0;
        wait_done(60, n);
        checks++;
        if (n < 0) begin
            errors++; $display("FAIL stall_done: timeout want done pulse");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {16'h0, 32'hAAAA_BBBB}) begin
            errors++; $display("FAIL stall_write: got %0d writes first %h want 1 write 0:AAAABBBB", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 48'h0);
        end
        checks++;
        if (acc != exp_acc || src_q.size() != 1 || src_q[0] !== 16'hCCCC) begin
            errors++; $display("FAIL stall_consume: accepted %0d left %0d want %0d accepted 1 left", acc, src_q.size(), exp_acc);
        end
        src_q.delete();
        stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero;
        int n;
        int exp_n;
`ifdef IM_LOADER_CHECKSUM_EN
        exp_n = 3;
`else
        exp_n = 1;
`endif
        wr_q.delete();
        push_trailer(32'h0);
        @(posedge clk);
        start(0);
        wait_done(20, n);
        checks++;
        if (n != exp_n || cpu_rst_f !== 1'b0) begin
            errors++; $display("FAIL zero_done: got %0d cycles cpu_rst_f=%b want %0d cycles cpu_rst_f=0", n, cpu_rst_f, exp_n);
        end
        @(negedge clk);
        checks++;
        if (cpu_rst_f !== 1'b1 || wr_q.size() != 0) begin
            errors++; $display("FAIL zero_release: cpu_rst_f=%b writes=%0d want 1 and 0", cpu_rst_f, wr_q.size());
        end
    endtask

    task automatic test_midreset;
        int n;
        bit found;
        wr_q.delete();
        src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        @(posedge clk);
        start(3);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.im_we) found = 1'b1;
        end
        @(negedge clk);
        rst_f = 1'b0;
        #1;
        checks++;
        if (!found || {busy, bus.s_ready, bus.im_we, done, cpu_rst_f} !== 5'b0 || bus.im_addr !== 16'h0) begin
            errors++; $display("FAIL midreset_state: found=%b ctl=%b addr=%h want 1 00000 0000", found, {busy, bus.s_ready, bus.im_we, done, cpu_rst_f}, bus.im_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {16'h0, 32'h1111_2222}) begin
            errors++; $display("FAIL midreset_partial: got %0d writes want 1 write 0:11112222", wr_q.size());
        end
        src_q.delete();
        rst_f = 1'b1;
        @(negedge clk);
        src_q = '{16'h7777, 16'h8888};
        push_trailer(32'h7777_8888);
        @(posedge clk);
        start(1);
        wait_done(30, n);
        checks++;
        if (n < 0 || wr_q.size() != 2 || wr_q[1] !== {16'h0, 32'h7777_8888}) begin
            errors++; $display("FAIL midreset_reload: n=%0d writes=%0d want write 0:77778888", n, wr_q.size());
        end
        @(negedge clk);
        checks++;
        if (cpu_rst_f !== 1'b1) begin
            errors++; $display("FAIL midreset_release: cpu_rst_f=%b want 1", cpu_rst_f);
        end
    endtask

`ifdef IM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int n;
        src_q = '{16'h0, 16'h1, 16'h0, 16'h2, 16'h0, 16'h3};
        @(posedge clk);
        start(2);
        wait_done(40, n);
        checks++;
        if (n < 0 || chk_ok !== 1'b1) begin
            errors++; $display("FAIL ck_good: n=%0d chk_ok=%b want 1", n, chk_ok);
        end
        @(negedge clk);
        checks++;
        if (cpu_rst_f !== 1'b1) begin
            errors++; $display("FAIL ck_good_release: cpu_rst_f=%b want 1", cpu_rst_f);
        end
        src_q = '{16'h0, 16'h1, 16'h0, 16'h2, 16'h0, 16'h0};
        @(posedge clk);
        start(2);
        wait_done(40, n);
        checks++;
        if (n < 0 || chk_ok !== 1'b0) begin
            errors++; $display("FAIL ck_bad: n=%0d chk_ok=%b want 0", n, chk_ok);
        end
        @(negedge clk);
        checks++;
        if (cpu_rst_f !== 1'b0) begin
            errors++; $display("FAIL ck_bad_hold: cpu_rst_f=%b want 0", cpu_rst_f);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_midreset();
`ifdef IM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
